// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array feeders and PE array.
package sa_pkg;

   // Skewer control states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } sa_state_e;

   // Default geometry shared with the PE array
   localparam int SA_N    = 8;
   localparam int SA_ROWS = 4;

   // Flush counter width; a single-row array still gets a 1-bit counter
   function automatic int sa_cnt_w(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/sa_skew_line.sv
// One row of the skew pipe: DEPTH registers that shift only on adv_i.
module sa_skew_line #(
   parameter int DEPTH = 1,
   parameter int N     = 8
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         adv_i,
   input  logic [N-1:0] in_i,
   output logic [N-1:0] out_o
);

   logic [DEPTH-1:0][N-1:0] stage_q;

   // Shift register; holds every stage when the array is not advancing
   always_ff @(posedge Clk) begin
      if (Rst) begin
         stage_q <= '0;
      end else if (adv_i) begin
         stage_q[0] <= in_i;
         for (int s = 1; s < DEPTH; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_feature_skewer.sv
// Left-edge feature feeder: skews row r by r advances, drives the PE
// advance/clear strobes and flushes the wavefront with zeros per tile.
module sa_feature_skewer
   import sa_pkg::*;
#(
   parameter int N    = SA_N,
   parameter int ROWS = SA_ROWS
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [ROWS*N-1:0] in_data,
   output logic [ROWS*N-1:0] F_out,
   output logic              compute_SA,
   output logic              Sclr,
   output logic              busy,
   output logic              tile_done
);

   localparam int            CW         = sa_cnt_w(ROWS);
   // Count value on the final flush advance (ROWS-1 flush steps total)
   localparam logic [CW-1:0] FLUSH_LAST = CW'((ROWS > 1) ? ROWS - 2 : 0);

   sa_state_e         state_q;
   logic [CW-1:0]     cnt_q;
   logic              compute_q;
   logic              sclr_q;
   logic              done_q;

   logic              accept;
   logic              advance;
   logic              first_beat;
   logic [ROWS*N-1:0] line_in;

   // Reset gates in_ready so no beat is taken while Rst is held
   assign in_ready   = ~Rst & ((state_q == IDLE) | (state_q == STREAM));
   assign accept     = in_valid & in_ready;
   assign advance    = accept | (state_q == FLUSH);
   // Only IDLE can see the opening beat of a tile
   assign first_beat = accept & (state_q == IDLE);
   // Zeros are pushed into every row while flushing
   assign line_in    = (state_q == FLUSH) ? '0 : in_data;

   // Tile FSM, flush counter and registered PE strobes
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         compute_q <= 1'b0;
         sclr_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         compute_q <= advance;
         sclr_q    <= first_beat;
         done_q    <= (state_q == DONE);
         unique case (state_q)
            IDLE, STREAM: begin
               if (accept) begin
                  if (!in_last)       state_q <= STREAM;
                  else if (ROWS == 1) state_q <= DONE;
                  else                state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (cnt_q == FLUSH_LAST) begin
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign compute_SA = compute_q;
   assign Sclr       = sclr_q;
   assign tile_done  = done_q;
   assign busy       = (state_q != IDLE);

   // Row r gets r+1 stages so column k reaches it on advance k+r+1
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      sa_skew_line #(
         .DEPTH (r + 1),
         .N     (N)
      ) u_line (
         .Clk   (Clk),
         .Rst   (Rst),
         .adv_i (advance),
         .in_i  (line_in[r*N +: N]),
         .out_o (F_out[r*N +: N])
      );
   end

endmodule

// File: tb/tb_sa_feature_skewer.sv
// Scoreboard bench for sa_feature_skewer (ROWS=4 random/directed, ROWS=1 directed).
module tb_sa_feature_skewer;

   localparam int N    = 8;
   localparam int ROWS = 4;
   localparam int W    = ROWS * N;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ROWS=4 instance
   logic         Rst, in_valid, in_ready, in_last;
   logic         compute_SA, Sclr, busy, tile_done;
   logic [W-1:0] in_data, F_out;

   // ROWS=1 instance
   logic         Rst1, v1, r1, l1, c1, s1, b1, d1;
   logic [N-1:0] din1, f1;

   sa_feature_skewer #(.N(N), .ROWS(ROWS)) dut (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_data(in_data), .F_out(F_out),
      .compute_SA(compute_SA), .Sclr(Sclr), .busy(busy), .tile_done(tile_done)
   );

   sa_feature_skewer #(.N(N), .ROWS(1)) dut1 (
      .Clk(Clk), .Rst(Rst1), .in_valid(v1), .in_ready(r1),
      .in_last(l1), .in_data(din1), .F_out(f1),
      .compute_SA(c1), .Sclr(s1), .busy(b1), .tile_done(d1)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] f;
      bit           sclr;
      bit           last;
   } exp_t;

   exp_t         q[$];      // one entry per expected PE advance
   logic [W-1:0] cols[$];   // columns of the tile in progress
   int           adv_n    = 0;
   bit           mon_en   = 0;
   bit           exp_zero = 1;
   bit           exp_done = 0;
   bit           done1    = 0;
   logic [W-1:0] prev_f;
   logic [W-1:0] tA [3];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Advance number adv_n of a tile: row r shows column adv_n-r-1, else zero
   function automatic void push_adv(input bit sclr, input bit last);
      exp_t         e;
      logic [W-1:0] c;
      int           k;
      adv_n++;
      e.f = '0;
      for (int r = 0; r < ROWS; r++) begin
         k = adv_n - r - 1;
         if (k >= 0 && k < cols.size()) begin
            c = cols[k];
            e.f[r*N +: N] = c[r*N +: N];
         end
      end
      e.sclr = sclr;
      e.last = last;
      q.push_back(e);
   endfunction

   // Present one beat until accepted; waits = cycles spent with in_ready low
   task automatic beat(input logic [W-1:0] d, input bit last, output int waits);
      bit first;
      waits    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready) begin
         @(posedge Clk); #1;
         waits++;
         if (waits > 40) begin
            chk("accept_timeout", 64'(waits), 0);
            in_valid = 1'b0;
            return;
         end
      end
      first = (cols.size() == 0);
      cols.push_back(d);
      push_adv(first, last && (ROWS == 1));
      if (last) begin
         for (int i = 1; i < ROWS; i++) push_adv(1'b0, i == ROWS - 1);
         cols.delete();
         adv_n = 0;
      end
      @(posedge Clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
      end
   endtask

   task automatic do_reset(input int n);
      Rst      = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = $urandom;
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
         chk("ready_in_reset", 64'(in_ready), 0);
      end
      Rst      = 1'b0;
      in_valid = 1'b0;
      cols.delete();
      adv_n = 0;
      #1;
      chk("ready_after_reset", 64'(in_ready), 1);
   endtask

   // Monitor: pops one expectation per compute_SA cycle, checks holds otherwise
   always @(negedge Clk) begin
      if (mon_en) begin
         exp_t e;
         if (exp_zero) begin
            chk("reset_state", 64'({compute_SA, Sclr, busy, tile_done, F_out}), 0);
            exp_zero = 0;
            exp_done = 0;
         end else begin
            chk("tile_done", 64'(tile_done), 64'(exp_done));
            exp_done = 0;
            if (compute_SA) begin
               if (q.size() == 0) begin
                  chk("unexpected_advance", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("F_out", 64'(F_out), 64'(e.f));
                  chk("Sclr", 64'(Sclr), 64'(e.sclr));
                  exp_done = e.last;
               end
            end else begin
               chk("hold", 64'({Sclr, F_out}), 64'({1'b0, prev_f}));
            end
         end
         prev_f = F_out;
         if (Rst) begin
            q.delete();
            exp_zero = 1;
            exp_done = 0;
         end
      end
   end

   // ROWS=4 stimulus
   initial begin
      int w;
      tA[0] = 32'h04030201;
      tA[1] = 32'h08070605;
      tA[2] = 32'h0C0B0A09;
      Rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      @(posedge Clk); #1;
      mon_en = 1;
      do_reset(3);

      // Basic three-column tile
      for (int i = 0; i < 3; i++) beat(tA[i], i == 2, w);
      idle(8);

      // Same tile with a two-cycle stall after the first beat
      beat(tA[0], 1'b0, w);
      idle(2);
      beat(tA[1], 1'b0, w);
      beat(tA[2], 1'b1, w);
      idle(8);

      // Single-beat tile
      beat(32'hDDCCBBAA, 1'b1, w);
      idle(8);

      // Reset while flushing, then a fresh tile
      beat(tA[0], 1'b0, w);
      beat(tA[1], 1'b1, w);
      idle(1);
      do_reset(1);
      idle(2);
      for (int i = 0; i < 3; i++) beat(tA[i], i == 2, w);

      // in_valid held across the boundary: blocked through FLUSH and DONE
      beat(32'h44332211, 1'b0, w);
      chk("ready_gap", 64'(w), 64'(ROWS));
      beat(32'h88776655, 1'b1, w);
      idle(8);

      // Random tiles with random stalls and gaps
      for (int t = 0; t < 25; t++) begin
         int c;
         c = $urandom_range(1, 6);
         for (int i = 0; i < c; i++) begin
            beat($urandom, i == c - 1, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
         if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 4));
      end

      in_valid = 1'b0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge Clk);
      idle(4);
      chk("scoreboard_drained", 64'(q.size()), 0);
      for (int i = 0; i < 200 && !done1; i++) @(posedge Clk);
      chk("rows1_finished", 64'(done1), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ROWS=1 directed checks: no flush, tile_done right after the only step
   initial begin
      Rst1 = 1'b1; v1 = 1'b0; l1 = 1'b0; din1 = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk("r1_reset", 64'({c1, s1, b1, d1, f1}), 0);
      Rst1 = 1'b0;
      #1;
      chk("r1_ready", 64'(r1), 1);
      v1 = 1'b1; din1 = 8'hAB; l1 = 1'b1;
      @(posedge Clk); #1;
      v1 = 1'b0;
      chk("r1_single", 64'({c1, s1, b1, d1, f1}), 64'({4'b1110, 8'hAB}));
      @(posedge Clk); #1;
      chk("r1_single_done", 64'({c1, s1, b1, d1}), 64'(4'b0001));
      @(posedge Clk); #1;
      for (int i = 0; i < 3; i++) begin
         v1   = 1'b1;
         din1 = 8'(8'h10 + i);
         l1   = (i == 2);
         @(posedge Clk); #1;
         chk("r1_multi", 64'({c1, s1, d1, f1}), 64'({1'b1, (i == 0), 1'b0, din1}));
      end
      v1 = 1'b0;
      @(posedge Clk); #1;
      chk("r1_multi_done", 64'({c1, d1}), 64'(2'b01));
      done1 = 1;
   end

endmodule
